hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Issue controller for the decode stage: tracks the in-flight register writes between decode and writeback, and stalls decode on read-after-write hazards.
- Sits beside the decode stage and register file. Consumes the decoded source/destination/write-enable fields and the writeback-stage write strobe.
- Drives the stall that freezes fetch/decode and bubbles the execute stage.

Parameters:
- NREGS, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- ADDR_W, 5, register address width (log2 NREGS).
- CNT_W, 2, per-register in-flight counter width; max in-flight writes per register = 2**CNT_W-1.
- WB_BYPASS, 1, 1 = register file write is visible to a same-cycle decode read, so a same-cycle retiring write does not stall.
- STAT_W, 32, stall statistics counter width.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  decode holds a valid instruction
- id_kill  input  1  decode instruction squashed this cycle (branch taken); never issues
- id_src1  input  ADDR_W  first source register
- id_src2  input  ADDR_W  second source register
- id_use_src2  input  1  src2 actually read (register operand or store data)
- id_wb_en  input  1  instruction writes a register
- id_dest  input  ADDR_W  destination register
- wb_en  input  1  writeback stage writes a register this cycle
- wb_dest  input  ADDR_W  writeback destination
- stall  output  1  hold fetch/decode, inject bubble into execute
- issue  output  1  decode instruction advances this cycle
- busy_vec  output  NREGS  bit r = register r has a pending write (registered)
- stall_count  output  STAT_W  saturating count of stall cycles

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, named rst.
- State: one CNT_W-bit counter per register 1..NREGS-1. Register 0 has a constant count of 0.
- Reset: all counters 0, busy_vec 0, stall_count 0. stall and issue are combinational and evaluate to 0 while counters are 0 and id_valid=0.
- Pending test for register r:
  - pend(r) = cnt[r]!=0.
  - With WB_BYPASS=1, pend(r) is cleared when cnt[r]==1 and wb_en and wb_dest==r in the same cycle.
- Full test: full(d) = id_wb_en and cnt[d]==max and not (wb_en and wb_dest==d).
- Stall: stall = id_valid & ~id_kill & (pend(id_src1) | (id_use_src2 & pend(id_src2)) | full(id_dest)). Source or destination 0 never stalls.
- Issue: issue = id_valid & ~id_kill & ~stall. Combinational, zero latency.
- Counter update, per register r on each clk edge:
  - inc = issue & id_wb_en & id_dest==r & r!=0.
  - dec = wb_en & wb_dest==r & r!=0.
  - inc only: +1. dec only: -1. Both or neither: hold.
- Underflow: dec with cnt==0 leaves the counter at 0. This is a spurious writeback and must not wrap.
- Overflow: prevented by full(); the counter never exceeds max.
- busy_vec: busy_vec[r] = cnt[r]!=0, derived from registered state (reflects counts after the last edge).
- stall_count: +1 on every edge where stall=1; saturates at all-ones. id_kill cycles never count.
- Simultaneous events: a retire and an issue to the same register in one cycle leave the count unchanged. With WB_BYPASS=0, a source whose last write retires this cycle still stalls this cycle and issues the next.
- Reset mid-operation: rst asserted asynchronously clears all counters and the stall counter immediately; in-flight writes are forgotten.

Decomposition:
- Shared package: NREGS, ADDR_W, the register-zero constant, and the CNT_W default, so the decode stage and register file use identical address widths.
- One natural sub-module: sb_reg_counter. It is a single up/down saturating counter with inc, dec, cnt and busy, and is instantiated NREGS-1 times by generate.
- Stall/issue decode stays in the top level.

Test Plan:
- Reset: assert rst mid-run with cnt[3]=2 -> busy_vec=0, stall_count=0 immediately, before the next clk edge.
- RAW stall: issue dest=5 (wb_en=1); next cycle decode src1=5, no wb -> stall=1, issue=0. Then wb_en=1, wb_dest=5 -> stall=0, issue=1 (WB_BYPASS=1), and busy_vec[5] falls after the edge.
- Register zero: issue dest=0, then src1=0, src2=0 -> never stalls, and busy_vec[0] stays 0.
- Saturation: issue dest=7 three times with no wb (cnt=3). A fourth writer to 7 -> stall=1 via full. With wb_dest=7 in the same cycle -> issue=1, and cnt stays 3.
- Kill: id_valid=1, id_kill=1, src1 busy -> stall=0, issue=0, no counter change, stall_count unchanged.
- Simultaneous: cnt[9]=1, issue dest=9 with wb_dest=9 in one cycle -> cnt[9] stays 1. Then a spurious wb_dest=12 with cnt[12]=0 -> cnt[12] stays 0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared register-file geometry for the decode-stage hazard scoreboard.
// Decode, the register file and the scoreboard all import the same address widths from here.
package hazard_scoreboard_pkg;

  localparam int NREGS         = 32;
  localparam int ADDR_W        = $clog2(NREGS);
  localparam int CNT_W_DEFAULT = 2;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/hazard_scoreboard_sb_reg_counter.sv
// Per-register in-flight write counter: up on issue, down on retire.
// It never wraps in either direction.
module sb_reg_counter #(
  parameter int CNT_W = hazard_scoreboard_pkg::CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A retire with nothing outstanding is a spurious writeback.
  // In that case the count stays at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: counts in-flight register writes per register.
// It stalls decode on read-after-write hazards and when a destination counter is full.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS     = hazard_scoreboard_pkg::NREGS,
  parameter int ADDR_W    = hazard_scoreboard_pkg::ADDR_W,
  parameter int CNT_W     = hazard_scoreboard_pkg::CNT_W_DEFAULT,
  parameter int WB_BYPASS = 1,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_kill,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_use_src2,
  input  logic              id_wb_en,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  output logic              stall,
  output logic              issue,
  output logic [NREGS-1:0]  busy_vec,
  output logic [STAT_W-1:0] stall_count
);

  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            busy_w;
  logic [NREGS-1:0]            pend_vec;
  logic [NREGS-1:0]            full_vec;
  logic [NREGS-1:0]            inc_vec;
  logic [NREGS-1:0]            dec_vec;
  logic [STAT_W-1:0]           stall_count_q;
  logic [STAT_W-1:0]           stall_count_d;

  assign cnt[0]    = '0;
  assign busy_w[0] = 1'b0;

  generate
    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
      sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc_vec[r]),
        .dec  (dec_vec[r]),
        .cnt  (cnt[r]),
        .busy (busy_w[r])
      );
    end
  endgenerate

  // With bypass, the last outstanding write retiring this cycle is already
  // visible to the register file read, so the register is no longer pending.
  always_comb begin
    pend_vec = '0;
    full_vec = '0;
    for (int r = 1; r < NREGS; r++) begin
      pend_vec[r] = (cnt[r] != '0) &&
                    !((WB_BYPASS != 0) && (cnt[r] == CNT_W'(1)) &&
                      wb_en && (wb_dest == ADDR_W'(r)));
      full_vec[r] = (cnt[r] == '1) && !(wb_en && (wb_dest == ADDR_W'(r)));
    end
  end

  always_comb begin
    stall = 1'b0;
    if (id_valid && !id_kill) begin
      stall = pend_vec[id_src1] |
              (id_use_src2 & pend_vec[id_src2]) |
              (id_wb_en & full_vec[id_dest]);
    end
    issue = id_valid & ~id_kill & ~stall;
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NREGS; r++) begin
      inc_vec[r] = issue && id_wb_en && (id_dest == ADDR_W'(r));
      dec_vec[r] = wb_en && (wb_dest == ADDR_W'(r));
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign busy_vec    = busy_w;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard with the default 32 registers.
// It uses 2-bit counters and write-back bypass enabled.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_kill = 1'b0;
  logic [4:0]  id_src1 = '0;
  logic [4:0]  id_src2 = '0;
  logic        id_use_src2 = 1'b0;
  logic        id_wb_en = 1'b0;
  logic [4:0]  id_dest = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_dest = '0;
  logic        stall;
  logic        issue;
  logic [31:0] busy_vec;
  logic [31:0] stall_count;

  int checkCount = 0;
  int passCount  = 0;

  hazard_scoreboard dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_kill     (id_kill),
    .id_src1     (id_src1),
    .id_src2     (id_src2),
    .id_use_src2 (id_use_src2),
    .id_wb_en    (id_wb_en),
    .id_dest     (id_dest),
    .wb_en       (wb_en),
    .wb_dest     (wb_dest),
    .stall       (stall),
    .issue       (issue),
    .busy_vec    (busy_vec),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive every decode and writeback input, then give the combinational logic time to settle.
  task automatic applyStimulus(input logic v, input logic k, input logic [4:0] s1,
                               input logic [4:0] s2, input logic u2, input logic we,
                               input logic [4:0] d, input logic wbe, input logic [4:0] wbd);
    id_valid = v; id_kill = k; id_src1 = s1; id_src2 = s2; id_use_src2 = u2;
    id_wb_en = we; id_dest = d; wb_en = wbe; wb_dest = wbd;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy_vec, 32'h0);
    checkOutput("reset_stall_count", stall_count, 32'h0);
    checkOutput("reset_stall", {31'b0, stall}, 32'h0);
    checkOutput("reset_issue", {31'b0, issue}, 32'h0);
    rst = 1'b0;
    cycle();

    // RAW hazard on r5, cleared by a same-cycle writeback through the bypass.
    applyStimulus(1, 0, 0, 0, 0, 1, 5, 0, 0);
    checkOutput("raw_first_issue", {31'b0, issue}, 32'h1);
    cycle();
    checkOutput("raw_busy5", busy_vec, 32'h0000_0020);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("raw_stall", {31'b0, stall}, 32'h1);
    checkOutput("raw_no_issue", {31'b0, issue}, 32'h0);
    cycle();
    checkOutput("raw_stall_count", stall_count, 32'h1);
    applyStimulus(1, 0, 5, 0, 0, 0, 0, 1, 5);
    checkOutput("bypass_no_stall", {31'b0, stall}, 32'h0);
    checkOutput("bypass_issue", {31'b0, issue}, 32'h1);
    cycle();
    checkOutput("raw_busy_clear", busy_vec, 32'h0);

    // Register zero is never tracked.
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("r0_dest_issue", {31'b0, issue}, 32'h1);
    cycle();
    checkOutput("r0_busy", busy_vec, 32'h0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("r0_src_no_stall", {31'b0, stall}, 32'h0);
    cycle();

    // Fill r7 to the maximum count of three.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
      checkOutput($sformatf("sat_issue%0d", i), {31'b0, issue}, 32'h1);
      cycle();
    end
    checkOutput("sat_busy7", busy_vec, 32'h0000_0080);
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
    checkOutput("sat_full_stall", {31'b0, stall}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 1, 7);
    checkOutput("sat_retire_issue", {31'b0, issue}, 32'h1);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 0, 0);
    checkOutput("sat_still_full", {31'b0, stall}, 32'h1);
    cycle();
    checkOutput("sat_stall_count", stall_count, 32'h2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7);
    cycle();
    cycle();
    checkOutput("sat_drain2_busy", busy_vec, 32'h0000_0080);
    cycle();
    checkOutput("sat_drain3_busy", busy_vec, 32'h0);

    // A killed decode neither stalls nor issues, even with a busy source.
    applyStimulus(1, 0, 0, 0, 0, 1, 10, 0, 0);
    cycle();
    applyStimulus(1, 1, 10, 0, 0, 1, 11, 0, 0);
    checkOutput("kill_stall", {31'b0, stall}, 32'h0);
    checkOutput("kill_issue", {31'b0, issue}, 32'h0);
    cycle();
    checkOutput("kill_busy", busy_vec, 32'h0000_0400);
    checkOutput("kill_stall_count", stall_count, 32'h2);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 10);
    cycle();
    checkOutput("kill_cleanup", busy_vec, 32'h0);

    // Issue and retire to r9 in the same cycle; then send a spurious retire to r12.
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 9, 1, 9);
    checkOutput("simul_issue", {31'b0, issue}, 32'h1);
    cycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12);
    cycle();
    checkOutput("spurious_busy", busy_vec, 32'h0000_0200);
    applyStimulus(1, 0, 0, 0, 0, 1, 12, 0, 0);
    cycle();
    checkOutput("r12_busy", busy_vec, 32'h0000_1200);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12);
    cycle();
    checkOutput("r12_no_wrap", busy_vec, 32'h0000_0200);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 9);
    cycle();
    checkOutput("r9_count_one", busy_vec, 32'h0);

    // src2 only matters when it is actually read.
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 0, 0);
    cycle();
    applyStimulus(1, 0, 0, 4, 0, 0, 0, 0, 0);
    checkOutput("src2_unused_issue", {31'b0, issue}, 32'h1);
    applyStimulus(1, 0, 0, 4, 1, 0, 0, 0, 0);
    checkOutput("src2_used_stall", {31'b0, stall}, 32'h1);
    cycle();
    checkOutput("src2_stall_count", stall_count, 32'h3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
    cycle();

    // An asynchronous reset with r3 at count 2 clears all state before the next edge.
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 0, 0);
    cycle();
    cycle();
    idle();
    checkOutput("pre_reset_busy", busy_vec, 32'h0000_0008);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_busy", busy_vec, 32'h0);
    checkOutput("async_reset_stall_count", stall_count, 32'h0);
    #1;
    rst = 1'b0;
    cycle();
    checkOutput("post_reset_busy", busy_vec, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
